y_gen: RTL
==========

// Module: y_gen
// PURPOSE
//  Forward-pass neuron evaluator: y = leaky_relu(sum_i(w_row[i]*x_in[i]) + bias) for one neuron.
//  Sequential MAC processes one vector element per cycle.
//  Produces the y_out entries that d_gen later consumes for backprop, and sits beside d_gen in the layer controller.
// PARAMETERS
//  N_INPUTS  4   vector length processed per neuron (<= `MAX_WIDTH); 1..`MAX_WIDTH legal
//  DATA_W    32  signed two's-complement width of all data (matches integer/ARR element)
// PORTS
//  CLK           in   1          single clock, rising edge
//  RST           in   1          synchronous, active-high reset
//  start         in   1          request; accepted only in IDLE with layer_index valid
//  layer_index   in   32         signed; valid range 0..`MAX_DEPTH-1
//  neuron_index  in   32         tag; echoed on neuron_out
//  x_in          in   ARR        input activations, element i = x_in[i]
//  w_row         in   ARR        weight row for this neuron
//  bias          in   DATA_W     signed bias
//  busy          out  1          high from cycle after accept until valid cycle inclusive
//  valid         out  1          one-cycle pulse; y_generated/y_pre_act/neuron_out are stable from this cycle until the next accept
//  y_generated   out  DATA_W     activated output
//  y_pre_act     out  DATA_W     pre-activation sum (bias included)
//  neuron_out    out  32         neuron_index latched at accept
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, valid=0, y_generated=0, y_pre_act=0, neuron_out=0; accumulator and counter=0.
//  Accept: start=1 in IDLE and 0<=layer_index<`MAX_DEPTH.
//   - x_in, w_row, bias and neuron_index are latched.
//   - acc<=bias, idx<=0.
//   - Input changes after accept have no effect.
//  start outside IDLE, or with layer_index out of range: ignored, no state change, no valid.
//  FSM:
//   - IDLE -> MAC on accept.
//   - MAC: acc<=acc+w[idx]*x[idx] (product truncated to DATA_W), idx++; after idx==N_INPUTS-1 -> ACT.
//   - ACT: y_pre_act<=acc; y_generated<=(acc<0)? acc/`LEAKY_RELU_SLOPE_DIVIDER : acc; -> DONE.
//   - DONE: valid=1 (registered), busy=1; -> IDLE.
//  Latency: accept at edge 0 -> valid high in cycle N_INPUTS+2. A new start is accepted the cycle after DONE.
//  Division is signed, truncating toward zero (-15/10=-1).
//  Arithmetic: wraps modulo 2^DATA_W unless MAC_SATURATE_EN is defined.
//  Activation: the same leaky activation applies on every layer, including `MAX_DEPTH-1.
//  RST mid-operation: returns to IDLE next edge, partial sum discarded, no valid pulse; RST wins over simultaneous start.
// CONFIGURATION
//  MAC_SATURATE_EN defined:
//   - Each product and each accumulate saturates to [-2^(DATA_W-1), 2^(DATA_W-1)-1] using a 2*DATA_W intermediate.
//   - Adds output sat_flag (1 bit): reset 0; set at accept-cycle+1 clear, OR of saturations, valid with valid.
//  MAC_SATURATE_EN undefined: plain wrap, no sat_flag port.
// STRUCTURE
//  library_file.v holds ARR typedef, `MAX_DEPTH, `MAX_WIDTH and `LEAKY_RELU_SLOPE_DIVIDER; no new constants elsewhere.
//  FSM state encoding is a localparam inside y_gen.
//  One sub-module: leaky_relu_act (combinational, DATA_W in/out, divide by `LEAKY_RELU_SLOPE_DIVIDER when negative).
//  It is reusable by d_gen-side refactors.
//  MAC datapath, counter and FSM are inline.
// TESTING (N_INPUTS=4, `LEAKY_RELU_SLOPE_DIVIDER=10, `MAX_DEPTH=3)
//  1 Positive sum: x={1,2,3,4}, w={1,1,1,1}, bias=0, layer 0 -> valid in cycle 6, y_pre_act=10, y_generated=10, busy=1 cycles 1..6.
//  2 Negative sum: x={1,2,3,4}, w={-10,-10,-10,-10}, bias=5 -> y_pre_act=-95, y_generated=-9.
//  3 Truncation/bias: x=0 vector, bias=-15, layer 2 -> y_generated=-1; neuron_index=7 -> neuron_out=7.
//  4 Guarding: layer_index=3 or -1 with start -> no busy, no valid.
//    start pulsed during MAC with different data -> ignored, first result unchanged.
//  5 Reset mid-op: RST in cycle 3 of case 1 -> busy=0, valid never pulses, all outputs 0.
//    Then a fresh case-1 start gives 10.
//  6 Overflow: x={32'h7FFFFFFF,1,0,0}, w={2,0,0,0}, bias=0.
//    Wrap build -> y_pre_act=-2, y_generated=0.
//    MAC_SATURATE_EN -> y_pre_act=32'h7FFFFFFF, sat_flag=1.

Source files
------------

// File: rtl/y_gen_pkg.sv
// Shared definitions for the neuron forward-pass evaluator (y_gen) and its
// d_gen neighbours: network-wide limits, the activation divider and the
// vector type that carries one row of activations or weights.

`ifndef Y_GEN_LIBRARY_DEFS
`define Y_GEN_LIBRARY_DEFS
`define MAX_DEPTH                3
`define MAX_WIDTH                8
`define LEAKY_RELU_SLOPE_DIVIDER 10
`endif

package y_gen_pkg;

    // Width of one vector element; matches a 32-bit integer.
    localparam int ARR_ELEM_W = 32;

    // One row of up to MAX_WIDTH signed elements, element i = vec[i].
    typedef logic [`MAX_WIDTH-1:0][ARR_ELEM_W-1:0] arr_t;

    // Index range check shared by every block that accepts a layer number.
    function automatic logic layer_in_range(input logic signed [31:0] layer);
        return (layer >= 32'sd0) && (layer < 32'sd`MAX_DEPTH);
    endfunction

endpackage

// File: rtl/y_gen_leaky_relu_act.sv
// Leaky ReLU activation: positive values pass through, negative values are
// divided by the slope divider with signed truncation toward zero
// (-15 -> -1, -95 -> -9). Purely combinational so it can be shared with
// the back-propagation side.

module leaky_relu_act #(
    parameter int DATA_W = 32
) (
    input  logic signed [DATA_W-1:0] act_in,
    output logic signed [DATA_W-1:0] act_out
);

    localparam logic signed [DATA_W-1:0] SLOPE_DIV = DATA_W'(`LEAKY_RELU_SLOPE_DIVIDER);

    // Select pass-through or scaled-down value on the sign of the input.
    always_comb begin
        act_out = act_in;
        if (act_in < 0) begin
            act_out = act_in / SLOPE_DIV;
        end
    end

endmodule

// File: rtl/y_gen.sv
// y_gen: single-neuron forward evaluator,
//   y = leaky_relu(sum_i(w_row[i] * x_in[i]) + bias).
// One multiply-accumulate per clock, then one activation cycle and a
// one-cycle result pulse. Operands are captured at accept so the caller may
// change its buses freely while the neuron is evaluating.
// Build option: MAC_SATURATE_EN -- when defined, every product and every
// accumulate clamps to the signed DATA_W range and a sat_flag output reports
// whether any clamp happened; otherwise arithmetic wraps.

module y_gen
    import y_gen_pkg::*;
#(
    parameter int N_INPUTS = 4,
    parameter int DATA_W   = 32
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     start,
    input  logic signed [31:0]       layer_index,
    input  logic        [31:0]       neuron_index,
    input  arr_t                     x_in,
    input  arr_t                     w_row,
    input  logic signed [DATA_W-1:0] bias,
    output logic                     busy,
    output logic                     valid,
    output logic signed [DATA_W-1:0] y_generated,
    output logic signed [DATA_W-1:0] y_pre_act,
`ifdef MAC_SATURATE_EN
    output logic                     sat_flag,
`endif
    output logic        [31:0]       neuron_out
);

    // State encoding kept local so the layer controller never depends on it.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MAC  = 2'd1;
    localparam logic [1:0] ST_ACT  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        MAC  = ST_MAC,
        ACT  = ST_ACT,
        DONE = ST_DONE
    } state_t;

    localparam int IDX_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_INPUTS - 1);

    state_t                     state_reg;
    logic signed [DATA_W-1:0]   acc_reg;
    logic        [IDX_W-1:0]    idx_reg;
    logic signed [DATA_W-1:0]   x_reg [N_INPUTS];
    logic signed [DATA_W-1:0]   w_reg [N_INPUTS];

    logic signed [DATA_W-1:0]   x_elem [N_INPUTS];
    logic signed [DATA_W-1:0]   w_elem [N_INPUTS];
    logic signed [DATA_W-1:0]   x_cur;
    logic signed [DATA_W-1:0]   w_cur;
    logic signed [DATA_W-1:0]   acc_next;
    logic signed [DATA_W-1:0]   act_value;
    logic                       accept;

    // Elements past N_INPUTS (and bits above DATA_W) are not part of this
    // neuron's row; fold them away so they do not look like dangling logic.
    logic unused_vec_bits;
    assign unused_vec_bits = ^{x_in, w_row};

    // Slice the packed row buses into per-element operands.
    for (genvar gi = 0; gi < N_INPUTS; gi++) begin : g_slice
        assign x_elem[gi] = x_in[gi][DATA_W-1:0];
        assign w_elem[gi] = w_row[gi][DATA_W-1:0];
    end

    assign accept = (state_reg == IDLE) && start && layer_in_range(layer_index);
    assign x_cur  = x_reg[idx_reg];
    assign w_cur  = w_reg[idx_reg];

`ifdef MAC_SATURATE_EN
    localparam logic signed [DATA_W-1:0]   SAT_MAX   = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0]   SAT_MIN   = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic signed [2*DATA_W-1:0] SAT_MAX_W = {{(DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [2*DATA_W-1:0] SAT_MIN_W = {{(DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    logic signed [2*DATA_W-1:0] prod_wide;
    logic signed [2*DATA_W-1:0] sum_wide;
    logic signed [DATA_W-1:0]   prod_sat;
    logic                       prod_ovf;
    logic                       sum_ovf;
    logic                       mac_sat;
    logic                       sat_reg;

    // Full-precision product and sum, each clamped back into DATA_W.
    always_comb begin
        prod_wide = $signed({{DATA_W{w_cur[DATA_W-1]}}, w_cur})
                  * $signed({{DATA_W{x_cur[DATA_W-1]}}, x_cur});
        prod_ovf  = (prod_wide > SAT_MAX_W) || (prod_wide < SAT_MIN_W);
        prod_sat  = prod_wide[DATA_W-1:0];
        if (prod_wide > SAT_MAX_W) begin
            prod_sat = SAT_MAX;
        end else if (prod_wide < SAT_MIN_W) begin
            prod_sat = SAT_MIN;
        end
        sum_wide = $signed({{DATA_W{acc_reg[DATA_W-1]}}, acc_reg})
                 + $signed({{DATA_W{prod_sat[DATA_W-1]}}, prod_sat});
        sum_ovf  = (sum_wide > SAT_MAX_W) || (sum_wide < SAT_MIN_W);
        acc_next = sum_wide[DATA_W-1:0];
        if (sum_wide > SAT_MAX_W) begin
            acc_next = SAT_MAX;
        end else if (sum_wide < SAT_MIN_W) begin
            acc_next = SAT_MIN;
        end
        mac_sat = prod_ovf || sum_ovf;
    end

    assign sat_flag = sat_reg;
`else
    // Plain modulo-2^DATA_W multiply-accumulate.
    always_comb begin
        acc_next = acc_reg + (w_cur * x_cur);
    end
`endif

    leaky_relu_act #(
        .DATA_W (DATA_W)
    ) u_act (
        .act_in  (acc_reg),
        .act_out (act_value)
    );

    // Control FSM, operand capture, accumulator and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg   <= IDLE;
            acc_reg     <= '0;
            idx_reg     <= '0;
            busy        <= 1'b0;
            valid       <= 1'b0;
            y_generated <= '0;
            y_pre_act   <= '0;
            neuron_out  <= '0;
            for (int i = 0; i < N_INPUTS; i++) begin
                x_reg[i] <= '0;
                w_reg[i] <= '0;
            end
`ifdef MAC_SATURATE_EN
            sat_reg     <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    valid <= 1'b0;
                    if (accept) begin
                        for (int i = 0; i < N_INPUTS; i++) begin
                            x_reg[i] <= x_elem[i];
                            w_reg[i] <= w_elem[i];
                        end
                        acc_reg    <= bias;
                        idx_reg    <= '0;
                        neuron_out <= neuron_index;
                        busy       <= 1'b1;
                        state_reg  <= MAC;
`ifdef MAC_SATURATE_EN
                        sat_reg    <= 1'b0;
`endif
                    end
                end
                MAC: begin
                    acc_reg <= acc_next;
                    idx_reg <= idx_reg + 1'b1;
`ifdef MAC_SATURATE_EN
                    sat_reg <= sat_reg | mac_sat;
`endif
                    if (idx_reg == LAST_IDX) begin
                        state_reg <= ACT;
                    end
                end
                ACT: begin
                    y_pre_act   <= acc_reg;
                    y_generated <= act_value;
                    valid       <= 1'b1;
                    state_reg   <= DONE;
                end
                DONE: begin
                    valid     <= 1'b0;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
